// File: rtl/button_fifo.sv
// button_fifo: synchronises and debounces NBTN game buttons, turns each
// debounced press into one queued entry holding the button index, and
// presents the oldest entry on dout for a 32-bit register.
// Optional feature macro: BTN_TIMESTAMP_EN adds a 16-bit free-running
// cycle counter whose value at the push edge lands in dout[31:16].
module button_fifo #(
  parameter int NBTN      = 4,
  parameter int DEPTH     = 8,
  parameter int DB_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic [NBTN-1:0]          btn_raw,
  input  logic                     pop,
  input  logic                     ovf_clr,
  output logic [31:0]              dout,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DB_CYCLES);

  logic [NBTN-1:0] sync1_q, sync2_q;
  logic [NBTN-1:0] db_q, db_d, dbPrev_q;
  logic [CW-1:0]   cnt_q [NBTN];
  logic [CW-1:0]   cnt_d [NBTN];
  logic [NBTN-1:0] pending_q, pending_d, grant;
  logic            push;
  logic [7:0]      pushIdx;
  logic [7:0]      idxMem_q [DEPTH];
  logic [AW-1:0]   rdPtr_q, rdPtr_d, wrPtr_q, wrPtr_d;
  logic [AW:0]     count_q, count_d;
  logic            overflow_q, overflow_d;
  logic            full, doPush, doPop, drop;
  logic [15:0]     tsHead;
`ifdef BTN_TIMESTAMP_EN
  logic [15:0]     ts_q;
  logic [15:0]     tsMem_q [DEPTH];
`endif

  // Two-flop synchroniser on every raw button line
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: flip db only after DB_CYCLES disagreeing samples in a row
  always_comb begin
    db_d = db_q;
    for (int i = 0; i < NBTN; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == db_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CW'(DB_CYCLES - 1)) begin
        cnt_d[i] = '0;
        db_d[i]  = ~db_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  // Lowest-index pending press wins the single push slot of this cycle
  always_comb begin
    push    = 1'b0;
    pushIdx = '0;
    for (int i = NBTN - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        push    = 1'b1;
        pushIdx = 8'(i);
      end
    end
    grant     = pending_q & (~pending_q + NBTN'(1));
    pending_d = (pending_q & ~grant) | (db_q & ~dbPrev_q);
  end

  // FIFO bookkeeping: a pop makes room for a push on the same edge
  always_comb begin
    full       = (count_q == (AW + 1)'(DEPTH));
    doPop      = pop & valid;
    doPush     = push & (~full | doPop);
    drop       = push & full & ~doPop;
    rdPtr_d    = doPop  ? rdPtr_q + 1'b1 : rdPtr_q;
    wrPtr_d    = doPush ? wrPtr_q + 1'b1 : wrPtr_q;
    count_d    = count_q;
    if (doPush && !doPop) count_d = count_q + 1'b1;
    if (doPop && !doPush) count_d = count_q - 1'b1;
    overflow_d = overflow_q;
    if (ovf_clr) overflow_d = 1'b0;
    if (drop)    overflow_d = 1'b1;
  end

  // Debounce, pending and queue control state
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      db_q       <= '0;
      dbPrev_q   <= '0;
      cnt_q      <= '{default: '0};
      pending_q  <= '0;
      rdPtr_q    <= '0;
      wrPtr_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      db_q       <= db_d;
      dbPrev_q   <= db_q;
      cnt_q      <= cnt_d;
      pending_q  <= pending_d;
      rdPtr_q    <= rdPtr_d;
      wrPtr_q    <= wrPtr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Entry storage needs no reset because dout is gated by valid
  always_ff @(posedge clk) begin
    if (doPush) idxMem_q[wrPtr_q] <= pushIdx;
  end

`ifdef BTN_TIMESTAMP_EN
  // Free-running cycle counter, wraps naturally at 16 bits
  always_ff @(posedge clk or posedge clr) begin
    if (clr) ts_q <= '0;
    else     ts_q <= ts_q + 16'd1;
  end

  // Timestamp captured alongside the index at the push edge
  always_ff @(posedge clk) begin
    if (doPush) tsMem_q[wrPtr_q] <= ts_q;
  end

  assign tsHead = tsMem_q[rdPtr_q];
`else
  assign tsHead = 16'h0000;
`endif

  assign valid    = (count_q != '0);
  assign count    = count_q;
  assign overflow = overflow_q;
  assign dout     = valid ? {tsHead, 8'h00, idxMem_q[rdPtr_q]} : 32'h0;

endmodule

// File: tb/tb_button_fifo.sv
// tb_button_fifo: directed stimulus for button_fifo with a scoreboard queue
// of expected entries, drained by a monitor that fires on every pop handshake.
module tb_button_fifo;

  localparam int NBTN  = 4;
  localparam int DEPTH = 8;
  localparam int DB    = 16;

  logic        clk = 1'b0;
  logic        clr;
  logic [3:0]  btnRaw;
  logic        pop;
  logic        ovfClr;
  logic [31:0] dout;
  logic        valid;
  logic [3:0]  count;
  logic        overflow;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] expQ [$];

  button_fifo #(.NBTN(NBTN), .DEPTH(DEPTH), .DB_CYCLES(DB)) dut (
    .clk      (clk),
    .clr      (clr),
    .btn_raw  (btnRaw),
    .pop      (pop),
    .ovf_clr  (ovfClr),
    .dout     (dout),
    .valid    (valid),
    .count    (count),
    .overflow (overflow)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clean press of button idx, long enough to queue, then a full release
  task automatic applyStimulus(input int idx);
    btnRaw[idx] = 1'b1;
    repeat (DB + 6) tick();
    btnRaw[idx] = 1'b0;
    repeat (DB + 4) tick();
  endtask

  // Stimulus plus a forked monitor that compares each popped head entry
  initial begin
    fork
      forever begin
        @(negedge clk);
        if (valid && pop) begin
          if (expQ.size() == 0) begin
            checkOutput("sb_unexpected_entry", 32'(expQ.size()), 32'd1);
          end else begin
            logic [31:0] e;
            e = expQ.pop_front();
`ifdef BTN_TIMESTAMP_EN
            checkOutput("sb_entry", {16'h0, dout[15:0]}, {16'h0, e[15:0]});
`else
            checkOutput("sb_entry", dout, e);
`endif
          end
        end
      end
    join_none

    clr    = 1'b1;
    btnRaw = '0;
    pop    = 1'b0;
    ovfClr = 1'b0;
    repeat (2) tick();
    checkOutput("reset_valid",    32'(valid),    32'd0);
    checkOutput("reset_count",    32'(count),    32'd0);
    checkOutput("reset_overflow", 32'(overflow), 32'd0);
    checkOutput("reset_dout",     dout,          32'd0);
    clr = 1'b0;

    // Single press latency: valid rises exactly DB+4 edges after first sample
    btnRaw = 4'b0001;
    repeat (DB + 3) tick();
    checkOutput("latency_early_valid", 32'(valid), 32'd0);
    tick();
    checkOutput("latency_valid", 32'(valid), 32'd1);
    checkOutput("latency_count", 32'(count), 32'd1);
    expQ.push_back(32'h0000_0000);
    btnRaw = '0;
    pop = 1'b1;
    tick();
    pop = 1'b0;
    checkOutput("pop_valid", 32'(valid), 32'd0);
    checkOutput("empty_dout", dout, 32'd0);
    pop = 1'b1;
    tick();
    pop = 1'b0;
    checkOutput("pop_empty_count", 32'(count), 32'd0);
    repeat (DB + 4) tick();

    // Short glitch must never reach the queue
    btnRaw[2] = 1'b1;
    repeat (5) tick();
    btnRaw[2] = 1'b0;
    repeat (DB + 8) tick();
    checkOutput("glitch_count", 32'(count), 32'd0);

    // Two buttons rising together queue lowest index first, one per cycle
    btnRaw = 4'b1010;
    repeat (DB + 3) tick();
    checkOutput("pair_count0", 32'(count), 32'd0);
    tick();
    checkOutput("pair_count1", 32'(count), 32'd1);
    checkOutput("pair_head", {16'h0, dout[15:0]}, 32'd1);
    tick();
    checkOutput("pair_count2", 32'(count), 32'd2);
    expQ.push_back(32'd1);
    expQ.push_back(32'd3);
    btnRaw = '0;
    repeat (DB + 4) tick();
    pop = 1'b1;
    repeat (2) tick();
    pop = 1'b0;
    checkOutput("pair_drained", 32'(count), 32'd0);

    // Nine presses into an eight-deep queue: last one dropped, overflow set
    for (int k = 0; k < 9; k++) begin
      if (k < 8) expQ.push_back(32'(k % 4));
      applyStimulus(k % 4);
      if (k == 7) checkOutput("fill_no_overflow", 32'(overflow), 32'd0);
    end
    checkOutput("full_count",    32'(count),    32'd8);
    checkOutput("full_overflow", 32'(overflow), 32'd1);
    ovfClr = 1'b1;
    tick();
    ovfClr = 1'b0;
    checkOutput("ovf_cleared",   32'(overflow), 32'd0);
    checkOutput("ovf_clr_count", 32'(count),    32'd8);

    // Push and pop on the same edge while full both succeed
    btnRaw[2] = 1'b1;
    repeat (DB + 3) tick();
    pop = 1'b1;
    tick();
    pop = 1'b0;
    expQ.push_back(32'd2);
    checkOutput("fullpp_count",    32'(count),    32'd8);
    checkOutput("fullpp_overflow", 32'(overflow), 32'd0);
    btnRaw = '0;
    repeat (DB + 4) tick();
    pop = 1'b1;
    repeat (8) tick();
    pop = 1'b0;
    checkOutput("drain_count", 32'(count), 32'd0);
    checkOutput("drain_valid", 32'(valid), 32'd0);

    // Reset with entries queued and a press mid-debounce discards everything
    for (int k = 1; k < 4; k++) begin
      applyStimulus(k);
    end
    checkOutput("preclr_count", 32'(count), 32'd3);
    btnRaw[0] = 1'b1;
    repeat (5) tick();
    clr = 1'b1;
    #1;
    checkOutput("clr_async_count", 32'(count), 32'd0);
    checkOutput("clr_async_valid", 32'(valid), 32'd0);
    checkOutput("clr_async_dout",  dout,       32'd0);
    expQ.delete();
    tick();
    clr = 1'b0;
    repeat (DB + 3) tick();
    checkOutput("reclr_early_valid", 32'(valid), 32'd0);
    tick();
    checkOutput("reclr_valid", 32'(valid), 32'd1);
    checkOutput("reclr_count", 32'(count), 32'd1);
`ifdef BTN_TIMESTAMP_EN
    checkOutput("reclr_timestamp", {16'h0, dout[31:16]}, 32'(DB + 3));
`endif
    expQ.push_back(32'd0);
    btnRaw = '0;
    pop = 1'b1;
    tick();
    pop = 1'b0;
    checkOutput("final_count", 32'(count), 32'd0);
    checkOutput("scoreboard_left", 32'(expQ.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
